// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter:
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT_RSP -> IDLE)
//   REQ_I/REQ_D : requester indices (instruction refill, data traffic)
//   req_onehot  : converts a requester index into its one-hot strobe
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] oh;
    oh = 2'b00;
    if (idx == 1'(REQ_D)) begin
      oh[REQ_D] = 1'b1;
    end else begin
      oh[REQ_I] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// External memory port bundle.
//   master : arbiter side (drives request, receives accept/response)
//   slave  : memory side
//   mem_req_valid/mem_req_ready : request handshake
//   mem_addr/mem_we/mem_wdata   : request payload
//   mem_rsp_valid/mem_rsp_rdata : one-cycle response / write ack
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_grant2.sv
// ---------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin grant.
//   req : request bits (bit0 = I-side, bit1 = D-side)
//   ptr : preferred requester when both request
//   gnt : one-hot grant, zero when nobody requests
// ---------------------------------------------------------------------------
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // A lone requester always wins; a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one external memory port between I-side refill (requester 0,
// read-only) and D-side traffic (requester 1, read or write-back).
// Round-robin grant, one transaction outstanding at a time.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : per-requester request / combinational accept strobe
//   req0_addr         : I-side read address
//   req1_addr/we/wdata: D-side request payload
//   rsp_valid/rdata   : registered completion pulse and read data
//   mem               : memory port (master side)
//   busy              : a transaction is in flight
//   spurious_rsp      : sticky, memory response seen while none expected
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_we,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  mem_port_arbiter_if.master    mem,
  output logic                  busy,
  output logic                  spurious_rsp
);

  arb_state_t            state_q,     state_d;
  logic                  rr_ptr_q,    rr_ptr_d;
  logic                  owner_q,     owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic                  we_q,        we_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  spur_q,      spur_d;
  logic [1:0]            gnt_s;
  logic [1:0]            req_ready_s;

  rr_grant2 u_rr_grant2 (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt_s)
  );

  // Next-state logic for the FSM and every register; reset is folded in
  // here so the flop block stays a plain register stage.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    spur_d      = spur_q;
    req_ready_s = 2'b00;

    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          req_ready_s = gnt_s;
          owner_d     = gnt_s[REQ_D];
          if (gnt_s[REQ_D]) begin
            addr_d  = req1_addr;
            we_d    = req1_we;
            wdata_d = req1_wdata;
          end else begin
            addr_d  = req0_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
        if (mem.mem_rsp_valid) begin
          spur_d = 1'b1;
        end else begin
          spur_d = spur_q;
        end
      end
      ISSUE: begin
        // A response coinciding with the accept cannot belong to this request.
        if (mem.mem_rsp_valid) begin
          spur_d = 1'b1;
        end else begin
          spur_d = spur_q;
        end
        if (mem.mem_req_ready) begin
          state_d = WAIT_RSP;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          rsp_valid_d = req_onehot(owner_q);
          rsp_rdata_d = we_q ? '0 : mem.mem_rsp_rdata;
          rr_ptr_d    = ~owner_q;
          state_d     = IDLE;
        end else begin
          state_d = WAIT_RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst_n) begin
      state_d     = IDLE;
      rr_ptr_d    = 1'b0;
      owner_d     = 1'b0;
      addr_d      = '0;
      we_d        = 1'b0;
      wdata_d     = '0;
      rsp_valid_d = 2'b00;
      rsp_rdata_d = '0;
      spur_d      = 1'b0;
      req_ready_s = 2'b00;
    end else begin
      req_ready_s = req_ready_s;
    end
  end

  // Register stage.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    rr_ptr_q    <= rr_ptr_d;
    owner_q     <= owner_d;
    addr_q      <= addr_d;
    we_q        <= we_d;
    wdata_q     <= wdata_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_rdata_q <= rsp_rdata_d;
    spur_q      <= spur_d;
  end

  assign req_ready         = req_ready_s;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign mem.mem_req_valid = (state_q == ISSUE);
  assign mem.mem_addr      = addr_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_wdata     = wdata_q;
  assign busy              = (state_q != IDLE);
  assign spurious_rsp      = spur_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Randomised stimulus for mem_port_arbiter compared each cycle against a
// transaction-level model of the arbitration and completion rules.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [AW-1:0] req1_addr = '0;
  logic          req1_we = 1'b0;
  logic [DW-1:0] req1_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          spurious_rsp;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_addr    (req0_addr),
    .req1_addr    (req1_addr),
    .req1_we      (req1_we),
    .req1_wdata   (req1_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem          (mif.master),
    .busy         (busy),
    .spurious_rsp (spurious_rsp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs, percentages
  int p_req0, p_req1, p_ready, p_rsp, p_spur, p_rst;
  bit force_rst;
  bit chk_alt;
  int prev_g;

  // pending requester FIFO heads
  bit rq_pend [2];

  // reference model: owner = -1 when the port is free
  int            m_owner;
  bit            m_issued;
  int            m_prefer;
  logic [AW-1:0] m_addr;
  bit            m_we;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_rsp_valid;
  logic [DW-1:0] m_rsp_rdata;
  bit            m_spur;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_issued = 1'b0; m_prefer = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    m_rsp_valid = 2'b00; m_rsp_rdata = '0; m_spur = 1'b0;
  endtask

  // One clock of stimulus, comparison and model advance.
  task automatic step();
    int g;
    logic [1:0] exp_ready;
    @(posedge clk);
    #1;
    rst_n = (force_rst || ($urandom_range(99) < p_rst)) ? 1'b0 : 1'b1;
    if (!rq_pend[0] && ($urandom_range(99) < p_req0)) begin
      rq_pend[0] = 1'b1;
      req0_addr  = $urandom() & 32'hFFFF_FFF0;
    end
    if (!rq_pend[1] && ($urandom_range(99) < p_req1)) begin
      rq_pend[1] = 1'b1;
      req1_addr  = $urandom() & 32'hFFFF_FFF0;
      req1_we    = $urandom_range(1);
      req1_wdata = rand_line();
    end
    req_valid = {rq_pend[1], rq_pend[0]};
    mif.mem_req_ready = ($urandom_range(99) < p_ready);
    if (m_owner >= 0 && m_issued) mif.mem_rsp_valid = ($urandom_range(99) < p_rsp);
    else                          mif.mem_rsp_valid = ($urandom_range(99) < p_spur);
    mif.mem_rsp_rdata = rand_line();

    @(negedge clk);
    // grant rule: a lone requester wins, a tie goes to the preferred side
    g = -1;
    if (m_owner < 0 && rst_n) begin
      if (rq_pend[0] && rq_pend[1]) g = m_prefer;
      else if (rq_pend[0])          g = 0;
      else if (rq_pend[1])          g = 1;
    end
    exp_ready = (g >= 0) ? (2'b01 << g) : 2'b00;
    check("req_ready",     DW'(req_ready),         DW'(exp_ready));
    check("mem_req_valid", DW'(mif.mem_req_valid), DW'(m_owner >= 0 && !m_issued));
    check("mem_addr",      DW'(mif.mem_addr),      DW'(m_addr));
    check("mem_we",        DW'(mif.mem_we),        DW'(m_we));
    check("mem_wdata",     mif.mem_wdata,          m_wdata);
    check("busy",          DW'(busy),              DW'(m_owner >= 0));
    check("rsp_valid",     DW'(rsp_valid),         DW'(m_rsp_valid));
    check("rsp_rdata",     rsp_rdata,              m_rsp_rdata);
    check("spurious_rsp",  DW'(spurious_rsp),      DW'(m_spur));
    if (chk_alt && req_ready != 2'b00) begin
      if (prev_g >= 0) check("alternate", DW'(req_ready[1]), DW'(1 - prev_g));
      prev_g = req_ready[1];
    end

    // advance the model across the coming edge
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rsp_valid = 2'b00;
      if (m_owner < 0) begin
        if (mif.mem_rsp_valid) m_spur = 1'b1;
        if (g >= 0) begin
          m_owner  = g;
          m_issued = 1'b0;
          m_addr   = (g == 1) ? req1_addr : req0_addr;
          m_we     = (g == 1) ? req1_we : 1'b0;
          m_wdata  = (g == 1) ? req1_wdata : '0;
          rq_pend[g] = 1'b0;
        end
      end else if (!m_issued) begin
        if (mif.mem_rsp_valid) m_spur = 1'b1;
        if (mif.mem_req_ready) m_issued = 1'b1;
      end else if (mif.mem_rsp_valid) begin
        m_rsp_valid = 2'b01 << m_owner;
        m_rsp_rdata = m_we ? '0 : mif.mem_rsp_rdata;
        m_prefer    = 1 - m_owner;
        m_owner     = -1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int r0, input int r1, input int rdy, input int rsp,
                       input int sp, input int rs);
    p_req0 = r0; p_req1 = r1; p_ready = rdy; p_rsp = rsp; p_spur = sp; p_rst = rs;
  endtask

  initial begin
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_rdata = '0;
    rq_pend[0] = 1'b0; rq_pend[1] = 1'b0;
    chk_alt = 1'b0; prev_g = -1;
    model_reset();

    // reset state
    knobs(0, 0, 0, 0, 0, 0);
    force_rst = 1'b1;
    run(3);
    force_rst = 1'b0;

    // I-side only, fast memory
    knobs(100, 0, 100, 100, 0, 0);
    run(20);

    // spurious response while idle, no requests
    knobs(0, 0, 0, 0, 0, 0);
    run(6);
    knobs(0, 0, 0, 0, 100, 0);
    run(1);
    knobs(0, 0, 0, 0, 0, 0);
    run(4);
    force_rst = 1'b1;
    run(1);
    force_rst = 1'b0;

    // both saturating: grants must alternate
    chk_alt = 1'b1; prev_g = -1;
    knobs(100, 100, 70, 60, 0, 0);
    run(200);
    chk_alt = 1'b0;

    // slow memory accept, mixed traffic
    knobs(50, 50, 20, 50, 0, 0);
    run(200);

    // stray responses mixed in
    knobs(40, 40, 50, 30, 5, 0);
    run(300);

    // occasional resets in any state
    knobs(60, 60, 50, 40, 3, 3);
    run(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
